// File: rtl/ofmap_stream_out.sv
// Output ofmap serializer: buffers wide accumulator words in a small FIFO and emits one lane per beat.
// Optional OFMAP_RELU_EN clamps negative beats to zero at the output mux.
module ofmap_stream_out #(
  parameter int unsigned OFMAP_WIDTH   = 32,
  parameter int unsigned ARRAY_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               config_enable,
  input  logic [COUNTER_WIDTH-1:0]           config_data,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] acc_dat,
  input  logic                               acc_vld,
  output logic                               acc_rdy,
  output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
  output logic                               ofmap_vld,
  input  logic                               ofmap_rdy,
  output logic                               layer_done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam int unsigned WW = OFMAP_WIDTH * ARRAY_WIDTH;

  logic [WW-1:0]            r_mem [FIFO_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [PW:0]              r_count;
  logic [LW-1:0]            r_lane_cnt;
  logic [COUNTER_WIDTH-1:0] r_word_cnt;
  logic [COUNTER_WIDTH-1:0] r_words_total;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_beat;
  logic                     w_last_lane;
  logic                     w_pop;
  logic                     w_layer_end;
  logic                     w_idle;
  logic [WW-1:0]            w_head;
  logic [OFMAP_WIDTH-1:0]   w_lane;
  logic [OFMAP_WIDTH-1:0]   w_beat_dat;

  assign w_full      = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = acc_vld && !w_full;
  assign w_beat      = !w_empty && ofmap_rdy;
  assign w_last_lane = (r_lane_cnt == LW'(ARRAY_WIDTH - 1));
  assign w_pop       = w_beat && w_last_lane;
  assign w_layer_end = w_pop && (r_words_total != '0) &&
                       ((r_word_cnt + COUNTER_WIDTH'(1)) == r_words_total);
  assign w_idle      = w_empty && (r_lane_cnt == '0) && (r_word_cnt == '0);

  assign acc_rdy    = !w_full;
  assign ofmap_vld  = !w_empty;
  assign layer_done = w_layer_end;
  assign w_head     = r_mem[r_rd_ptr];

  always_comb begin
    w_lane = '0;
    for (int unsigned i = 0; i < ARRAY_WIDTH; i++) begin
      if (r_lane_cnt == LW'(i)) w_lane = w_head[i*OFMAP_WIDTH +: OFMAP_WIDTH];
    end
  end

`ifdef OFMAP_RELU_EN
  assign w_beat_dat = w_lane[OFMAP_WIDTH-1] ? '0 : w_lane;
`else
  assign w_beat_dat = w_lane;
`endif

  // Storage is not reset; stale entries are unreachable once the occupancy count clears.
  assign ofmap_dat = w_empty ? '0 : w_beat_dat;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= acc_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_lane_cnt    <= '0;
      r_word_cnt    <= '0;
      r_words_total <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);

      if (w_beat) r_lane_cnt <= w_last_lane ? '0 : r_lane_cnt + LW'(1);

      if (w_layer_end)  r_word_cnt <= '0;
      else if (w_pop)   r_word_cnt <= r_word_cnt + COUNTER_WIDTH'(1);

      if (config_enable && w_idle) r_words_total <= config_data;
    end
  end

endmodule

// File: tb/tb_ofmap_stream_out.sv
// Bench for ofmap_stream_out: a word-queue reference model predicts every output each cycle.
module tb_ofmap_stream_out;
  localparam int unsigned OW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned CW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           config_enable;
  logic [CW-1:0]  config_data;
  logic [OW*AW-1:0] acc_dat;
  logic           acc_vld;
  logic           acc_rdy;
  logic [OW-1:0]  ofmap_dat;
  logic           ofmap_vld;
  logic           ofmap_rdy;
  logic           layer_done;

  ofmap_stream_out #(
    .OFMAP_WIDTH(OW), .ARRAY_WIDTH(AW), .FIFO_DEPTH(FD), .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .config_enable(config_enable), .config_data(config_data),
    .acc_dat(acc_dat), .acc_vld(acc_vld), .acc_rdy(acc_rdy),
    .ofmap_dat(ofmap_dat), .ofmap_vld(ofmap_vld), .ofmap_rdy(ofmap_rdy),
    .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  // Reference model: queue of accepted words, lane position, words popped since last accepted config.
  logic [OW*AW-1:0] q[$];
  int unsigned mlane  = 0;
  int unsigned total  = 0;
  int unsigned popped = 0;
  int unsigned beats_seen = 0;
  int unsigned done_seen  = 0;

  function automatic logic [OW-1:0] relu(input logic [OW-1:0] v);
`ifdef OFMAP_RELU_EN
    return v[OW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic step();
    logic [OW*AW-1:0] head;
    logic [OW-1:0]    ed;
    logic             ev, er, edone;
    int unsigned      wc;
    #1;
    ev = (q.size() != 0);
    er = (q.size() < FD);
    ed = '0;
    if (ev) begin
      head = q[0];
      ed = relu(head[mlane*OW +: OW]);
    end
    edone = ev && ofmap_rdy && (mlane == AW-1) && (total != 0) && ((popped + 1) % total == 0);
    check("ofmap_vld", ofmap_vld, ev);
    check("acc_rdy", acc_rdy, er);
    check("ofmap_dat", ofmap_dat, ed);
    check("layer_done", layer_done, edone);
    if (ofmap_vld && ofmap_rdy) beats_seen++;
    if (layer_done) done_seen++;

    wc = (total == 0) ? popped : (popped % total);
    if (config_enable && ev == 1'b0 && mlane == 0 && wc == 0) begin
      total  = config_data;
      popped = 0;
    end
    if (ev && ofmap_rdy) begin
      if (mlane == AW-1) begin
        mlane = 0;
        void'(q.pop_front());
        popped++;
      end else begin
        mlane++;
      end
    end
    if (acc_vld && er) q.push_back(acc_dat);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [OW*AW-1:0] rand_word();
    logic [OW*AW-1:0] w;
    for (int i = 0; i < AW; i++) w[i*OW +: OW] = $urandom;
    return w;
  endfunction

  initial begin
    int unsigned sent;
    int unsigned cyc;
    int unsigned beats_base;
    int unsigned done_base;

    rst_n = 1'b0; config_enable = 1'b0; config_data = '0;
    acc_dat = '0; acc_vld = 1'b0; ofmap_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_vld", ofmap_vld, 1'b0);
    check("rst_rdy", acc_rdy, 1'b1);
    check("rst_dat", ofmap_dat, 64'd0);
    check("rst_done", layer_done, 1'b0);
    rst_n = 1'b1;
    step();

    // 1: two words, layer of 2, free-flowing output
    config_enable = 1'b1; config_data = 2; step(); config_enable = 1'b0;
    ofmap_rdy = 1'b1;
    acc_vld = 1'b1; acc_dat = {32'd4, 32'd3, 32'd2, 32'd1}; step();
    acc_dat = {32'd8, 32'd7, 32'd6, 32'd5}; step();
    acc_vld = 1'b0;
    repeat (10) step();
    check("t1_done_count", done_seen, 64'd1);

    // 2: fill with output stalled, then drain
    ofmap_rdy = 1'b0; acc_vld = 1'b1;
    repeat (5) begin acc_dat = rand_word(); step(); end
    acc_vld = 1'b0;
    check("t2_full_rdy", acc_rdy, 1'b0);
    repeat (3) step();
    ofmap_rdy = 1'b1;
    repeat (20) step();
    check("t2_drained", ofmap_vld, 1'b0);

    // 3: random back-pressure over 100 words
    config_enable = 1'b1; config_data = 4; step(); config_enable = 1'b0;
    beats_base = beats_seen;
    sent = 0; cyc = 0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      acc_vld   = (sent < 100) && ($urandom_range(0, 1) == 1);
      acc_dat   = rand_word();
      ofmap_rdy = ($urandom_range(0, 3) != 0);
      if (acc_vld && q.size() < FD) sent++;
      step();
      cyc++;
    end
    acc_vld = 1'b0; ofmap_rdy = 1'b0;
    check("t3_timeout", (cyc < 3000), 1'b1);
    check("t3_beats", beats_seen - beats_base, 64'd400);

    // 4: config 5, late config 9 ignored; then config 0 never finishes a layer
    config_enable = 1'b1; config_data = 5; step(); config_enable = 1'b0;
    done_base = done_seen;
    ofmap_rdy = 1'b1;
    acc_vld = 1'b1; acc_dat = rand_word(); step();
    acc_vld = 1'b0; step();
    config_enable = 1'b1; config_data = 9; step(); config_enable = 1'b0;
    repeat (4) begin
      acc_vld = 1'b1; acc_dat = rand_word(); step();
      acc_vld = 1'b0; repeat (3) step();
    end
    repeat (10) step();
    check("t4_done5", done_seen - done_base, 64'd1);
    config_enable = 1'b1; config_data = 0; step(); config_enable = 1'b0;
    done_base = done_seen;
    acc_vld = 1'b1;
    repeat (3) begin acc_dat = rand_word(); step(); end
    acc_vld = 1'b0;
    repeat (16) step();
    check("t4_done0", done_seen - done_base, 64'd0);

    // 5: reset with three words queued, head at lane 2
    ofmap_rdy = 1'b0; acc_vld = 1'b1;
    repeat (3) begin acc_dat = rand_word(); step(); end
    acc_vld = 1'b0; ofmap_rdy = 1'b1;
    repeat (2) step();
    ofmap_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_async_vld", ofmap_vld, 1'b0);
    check("t5_async_rdy", acc_rdy, 1'b1);
    q.delete(); mlane = 0; total = 0; popped = 0;
    ofmap_rdy = 1'b1;
    step();
    rst_n = 1'b1;
    acc_vld = 1'b1; acc_dat = {32'd44, 32'd33, 32'd22, 32'd11}; step();
    acc_vld = 1'b0;
    check("t5_first_lane", ofmap_dat, 64'd11);
    repeat (6) step();

    // 6: sign-bit lanes through the output mux
    acc_vld = 1'b1; acc_dat = {32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF}; step();
    acc_vld = 1'b0;
`ifdef OFMAP_RELU_EN
    check("t6_lane0", ofmap_dat, 64'd0);
`else
    check("t6_lane0", ofmap_dat, 64'hFFFF_FFFF);
`endif
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
